gtech_parity_arb: RTL and testbench
===================================

GTECH_PARITY_ARB -- requirements
Module: gtech_parity_arb

Interface
REQ-001 Parameter: WIDTH, default 8, data word width in bits; SHALL be even and >= 2.
REQ-002 Port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 Port: RST  input  1  reset, synchronous, active-high.
REQ-004 Port: REQ0  input  1  requester 0 has a word pending.
REQ-005 Port: DATA0  input  WIDTH  requester 0 word; sampled only in the ACK0 cycle.
REQ-006 Port: ACK0  output  1  one-cycle pulse: requester 0 word accepted.
REQ-007 Port: REQ1  input  1  requester 1 has a word pending.
REQ-008 Port: DATA1  input  WIDTH  requester 1 word; sampled only in the ACK1 cycle.
REQ-009 Port: ACK1  output  1  one-cycle pulse: requester 1 word accepted.
REQ-010 Port: BUSY  output  1  high whenever state is not IDLE.
REQ-011 Port: DONE  output  1  one-cycle pulse: Z and ID valid.
REQ-012 Port: ID  output  1  requester that owns the current result (0 or 1).
REQ-013 Port: Z  output  1  XNOR reduction of the accepted word (1 = even number of ones).

Function
REQ-014 The block SHALL time-share one 3-input XNOR stage: acc_next = ~(acc ^ bit_a ^ bit_b), two data bits per cycle.
REQ-015 The FSM SHALL have states IDLE, RUN and DONE, encoded in 2 bits.
REQ-016 IDLE: when at least one REQ is high, the block SHALL grant one requester, pulse its ACK, latch its DATA and ID, and go to RUN on the next edge.
REQ-017 ACK SHALL be combinational from state, REQ and the priority pointer, and high only in IDLE.
REQ-018 RUN SHALL last exactly WIDTH/2 cycles, counted by a step counter of ceil(log2(WIDTH/2))+1 bits; the block SHALL then go to DONE.
REQ-019 DONE SHALL last one cycle with DONE=1, then return to IDLE; no grant is issued in DONE.
REQ-020 Latency: ACK in cycle t gives DONE in cycle t+WIDTH/2+1; the minimum grant-to-grant spacing is WIDTH/2+2 cycles.
REQ-021 Z SHALL equal ~^word exactly; the accumulator seed SHALL compensate for the WIDTH/2 inversions of the chained XNOR stages.
REQ-022 Z and ID SHALL hold their values from the DONE cycle until the next DONE cycle.
REQ-023 Arbitration is round-robin with a 1-bit last-served pointer: on simultaneous REQ0 and REQ1, the requester not last served wins.
REQ-024 The pointer SHALL update only in a cycle in which an ACK is issued.
REQ-025 A REQ deasserted before its ACK SHALL be dropped with no side effect.
REQ-026 A REQ still high after its ACK SHALL count as a new request.
REQ-027 REQ and DATA changes during RUN or DONE SHALL NOT affect the word in flight.

Reset
REQ-028 With RST=1 at a rising edge, the following SHALL be forced: state=IDLE, counter=0, pointer=1 (requester 0 wins the first tie), Z=0, ID=0.
REQ-029 During reset, ACK0, ACK1, BUSY and DONE SHALL be held at 0.
REQ-030 RST asserted mid-RUN SHALL abort the word in flight; no DONE is produced for it.
REQ-031 A REQ high in the first cycle after reset release SHALL be granted in that cycle.

Configuration
REQ-032 Macro GTECH_PARITY_ARB_FIXED_PRIO_EN: when defined, arbitration SHALL be fixed priority (REQ0 always wins a tie) and the pointer SHALL NOT be instantiated.
REQ-033 When GTECH_PARITY_ARB_FIXED_PRIO_EN is undefined, round-robin per REQ-023/024 SHALL apply.

Verification
REQ-034 WIDTH=8; REQ0=1 with DATA0=8'hA5 in cycle 2 after reset -> ACK0 in cycle 2, BUSY cycles 3-7, DONE in cycle 7 with Z=1, ID=0.
REQ-035 DATA1=8'h07 via REQ1 -> DONE with Z=0, ID=1, 5 cycles after ACK1.
REQ-036 REQ0 and REQ1 held high for 4 grants -> ACK order 0,1,0,1, spaced 6 cycles apart.
REQ-037 Same stimulus as REQ-036 with GTECH_PARITY_ARB_FIXED_PRIO_EN defined -> ACK order 0,0,0,0.
REQ-038 RST pulsed during the 2nd RUN cycle -> no DONE; Z=0; the next request is granted in IDLE with a correct result.
REQ-039 REQ1 pulsed for one cycle during RUN, and DATA0 changed during RUN -> no ACK1 later; in-flight Z is unchanged.

Source files
------------

// File: rtl/gtech_parity_arb.sv
// gtech_parity_arb
//   Two-requester arbiter in front of a time-shared parity engine. A granted
//   word is folded two bits per cycle through a single 3-input XNOR stage,
//   and the resulting even-parity flag is presented on Z with the owner's ID.
//
// Parameters
//   WIDTH  data word width in bits (even, >= 2)
//
// Ports
//   CLK    clock, all state changes on the rising edge
//   RST    synchronous active-high reset
//   REQ0   requester 0 has a word pending
//   DATA0  requester 0 word, captured in the ACK0 cycle
//   ACK0   one-cycle pulse, requester 0 word accepted
//   REQ1   requester 1 has a word pending
//   DATA1  requester 1 word, captured in the ACK1 cycle
//   ACK1   one-cycle pulse, requester 1 word accepted
//   BUSY   high while a word is being processed or reported
//   DONE   one-cycle pulse, Z and ID are valid
//   ID     requester owning the current result
//   Z      1 when the accepted word has an even number of ones
//
// Build option
//   GTECH_PARITY_ARB_FIXED_PRIO_EN  when defined, requester 0 always wins a
//   tie and no last-served pointer exists; otherwise round-robin.

module gtech_parity_arb #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic [WIDTH-1:0] DATA0,
  output logic             ACK0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] DATA1,
  output logic             ACK1,
  output logic             BUSY,
  output logic             DONE,
  output logic             ID,
  output logic             Z
);

  localparam int STEPS = WIDTH / 2;
  localparam int CNT_W = $clog2(STEPS) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);
  // Each XNOR stage adds one inversion; an even number of stages cancels,
  // so the seed must be 1 for even STEPS and 0 for odd STEPS to land on ~^word.
  localparam logic SEED = ((STEPS % 2) == 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic             owner_q, owner_d;
  logic             z_q, z_d;
  logic             id_q, id_d;

  logic             win0, win1;
  logic             grant;
  logic             accStep;

`ifdef GTECH_PARITY_ARB_FIXED_PRIO_EN
  // Requester 0 always wins a tie.
  assign win0 = REQ0;
  assign win1 = REQ1 & ~REQ0;
`else
  logic ptr_q;

  // On a tie the requester that was not served last wins; ptr_q = 1 means
  // requester 1 was served last.
  assign win0 = REQ0 & (~REQ1 | ptr_q);
  assign win1 = REQ1 & (~REQ0 | ~ptr_q);

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q <= 1'b1;
    end else if (grant) begin
      ptr_q <= ACK1;
    end
  end
`endif

  // Grants only exist in IDLE and are suppressed while reset is asserted.
  assign ACK0  = ~RST & (state_q == ST_IDLE) & win0;
  assign ACK1  = ~RST & (state_q == ST_IDLE) & win1;
  assign grant = ACK0 | ACK1;
  assign BUSY  = ~RST & (state_q != ST_IDLE);
  assign DONE  = ~RST & (state_q == ST_DONE);
  assign Z     = z_q;
  assign ID    = id_q;

  // The single shared XNOR stage consumes the two low bits of the word.
  assign accStep = ~(acc_q ^ word_q[0] ^ word_q[1]);

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    owner_d = owner_q;
    z_d     = z_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d = ST_RUN;
          word_d  = ACK1 ? DATA1 : DATA0;
          owner_d = ACK1;
          acc_d   = SEED;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        acc_d  = accStep;
        word_d = word_q >> 2;
        cnt_d  = cnt_q + CNT_W'(1);
        // Result and owner are published together on entry to DONE and
        // then held until the next word completes.
        if (cnt_q == LAST_STEP) begin
          state_d = ST_DONE;
          z_d     = accStep;
          id_d    = owner_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      owner_q <= 1'b0;
      z_q     <= 1'b0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      owner_q <= owner_d;
      z_q     <= z_d;
      id_q    <= id_d;
    end
  end

endmodule

// File: tb/tb_gtech_parity_arb.sv
// tb_gtech_parity_arb
//   Directed and randomized stimulus for gtech_parity_arb. The reference
//   model tracks grants by cycle number: a grant at cycle g makes the block
//   busy until g+N+1, reports at g+N+1 and frees it at g+N+2. Parity is
//   taken from a population count of the granted word.

module tb_gtech_parity_arb;

  localparam int WIDTH = 8;
  localparam int N     = WIDTH / 2;

  logic             CLK;
  logic             RST;
  logic             REQ0;
  logic [WIDTH-1:0] DATA0;
  logic             ACK0;
  logic             REQ1;
  logic [WIDTH-1:0] DATA1;
  logic             ACK1;
  logic             BUSY;
  logic             DONE;
  logic             ID;
  logic             Z;

  int   errors     = 0;
  int   checks     = 0;
  int   cyc        = 0;
  int   nextFree   = 0;
  int   doneAt     = -1;
  logic lastServed = 1'b1;
  logic mZ         = 1'b0;
  logic mId        = 1'b0;
  logic pendZ      = 1'b0;
  logic pendId     = 1'b0;
  logic eAck0, eAck1, eBusy, eDone;
  bit   logAcks    = 1'b0;
  int   ackLog[$];
  int   expOrder[4];

  gtech_parity_arb #(.WIDTH(WIDTH)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .REQ0  (REQ0),
    .DATA0 (DATA0),
    .ACK0  (ACK0),
    .REQ1  (REQ1),
    .DATA1 (DATA1),
    .ACK1  (ACK1),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .ID    (ID),
    .Z     (Z)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic evenOnes(input logic [WIDTH-1:0] w);
    return (($countones(w) % 2) == 0);
  endfunction

  // Compares all outputs with the model's expectations for this cycle.
  task automatic checkOutput(input bit inReset);
    checks++;
    assert (ACK0 === eAck0) else begin
      errors++;
      $error("[TB] FAIL ack0 cyc=%0d observed=%b expected=%b", cyc, ACK0, eAck0);
    end
    checks++;
    assert (ACK1 === eAck1) else begin
      errors++;
      $error("[TB] FAIL ack1 cyc=%0d observed=%b expected=%b", cyc, ACK1, eAck1);
    end
    checks++;
    assert (BUSY === eBusy) else begin
      errors++;
      $error("[TB] FAIL busy cyc=%0d observed=%b expected=%b", cyc, BUSY, eBusy);
    end
    checks++;
    assert (DONE === eDone) else begin
      errors++;
      $error("[TB] FAIL done cyc=%0d observed=%b expected=%b", cyc, DONE, eDone);
    end
    if (!inReset) begin
      checks++;
      assert (Z === mZ) else begin
        errors++;
        $error("[TB] FAIL z cyc=%0d observed=%b expected=%b", cyc, Z, mZ);
      end
      checks++;
      assert (ID === mId) else begin
        errors++;
        $error("[TB] FAIL id cyc=%0d observed=%b expected=%b", cyc, ID, mId);
      end
    end
  endtask

  // Drives one cycle of inputs, checks outputs mid-cycle, advances the model.
  task automatic applyStimulus(input logic rst, input logic r0, input logic [WIDTH-1:0] d0,
                               input logic r1, input logic [WIDTH-1:0] d1);
    bit idle;
    bit anyReq;
    bit w;
    RST   = rst;
    REQ0  = r0;
    DATA0 = d0;
    REQ1  = r1;
    DATA1 = d1;
    #2;
    if (rst) begin
      eAck0 = 1'b0;
      eAck1 = 1'b0;
      eBusy = 1'b0;
      eDone = 1'b0;
      checkOutput(1'b1);
      lastServed = 1'b1;
      mZ         = 1'b0;
      mId        = 1'b0;
      nextFree   = cyc + 1;
      doneAt     = -1;
    end else begin
      idle   = (cyc >= nextFree);
      anyReq = r0 | r1;
`ifdef GTECH_PARITY_ARB_FIXED_PRIO_EN
      w = !r0;
`else
      w = (r0 && r1) ? !lastServed : r1;
`endif
      eAck0 = idle && anyReq && !w;
      eAck1 = idle && anyReq && w;
      eBusy = !idle;
      eDone = (cyc == doneAt);
      if (eDone) begin
        mZ  = pendZ;
        mId = pendId;
      end
      checkOutput(1'b0);
      if (logAcks && (ACK0 || ACK1)) ackLog.push_back(int'(ACK1));
      if (idle && anyReq) begin
        lastServed = w;
        pendZ      = evenOnes(w ? d1 : d0);
        pendId     = w;
        doneAt     = cyc + N + 1;
        nextFree   = cyc + N + 2;
      end
    end
    cyc++;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic             rr, q0, q1;
    logic [WIDTH-1:0] v0, v1;
    RST   = 1'b1;
    REQ0  = 1'b0;
    REQ1  = 1'b0;
    DATA0 = '0;
    DATA1 = '0;

    // Reset, then one idle cycle.
    applyStimulus(1'b1, 1'b1, 8'hFF, 1'b1, 8'hFF);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);

    // Requester 0 with an even-parity word.
    applyStimulus(1'b0, 1'b1, 8'hA5, 1'b0, 8'h00);
    repeat (N + 1) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);

    // Requester 1 with an odd-parity word, granted at minimum spacing.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 8'h07);
    repeat (N + 1) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);

    // Both requests held high across four grants.
    logAcks = 1'b1;
    repeat (4 * (N + 2)) applyStimulus(1'b0, 1'b1, 8'h3C, 1'b1, 8'h81);
    logAcks = 1'b0;
`ifdef GTECH_PARITY_ARB_FIXED_PRIO_EN
    expOrder = '{0, 0, 0, 0};
`else
    expOrder = '{0, 1, 0, 1};
`endif
    checks++;
    assert (ackLog.size() == 4) else begin
      errors++;
      $error("[TB] FAIL ackCount observed=%0d expected=4", ackLog.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      assert (((i < ackLog.size()) ? ackLog[i] : -1) == expOrder[i]) else begin
        errors++;
        $error("[TB] FAIL ackOrder[%0d] observed=%0d expected=%0d", i,
               (i < ackLog.size()) ? ackLog[i] : -1, expOrder[i]);
      end
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);

    // Reset during the second RUN cycle aborts the word.
    applyStimulus(1'b0, 1'b1, 8'hF0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    repeat (N + 2) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 8'h33);
    repeat (N + 1) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);

    // Short REQ1 pulse and DATA0 churn while a word is in flight.
    applyStimulus(1'b0, 1'b1, 8'h01, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'hFF, 1'b1, 8'hAA);
    repeat (N + 1) applyStimulus(1'b0, 1'b0, WIDTH'($urandom), 1'b0, WIDTH'($urandom));

    // Randomized traffic with occasional resets.
    repeat (400) begin
      rr = ($urandom_range(0, 49) == 0);
      q0 = 1'($urandom_range(0, 1));
      q1 = 1'($urandom_range(0, 1));
      v0 = WIDTH'($urandom);
      v1 = WIDTH'($urandom);
      applyStimulus(rr, q0, v0, q1, v1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
